global_mem_responder: RTL and testbench

Responder side of the global-memory handshake used by the GPU cores. It arbitrates among `NUM_CORES` cores that hold `readingMemoryDataGlobal` or `writingMemoryDataGlobal` high with their MAR/MDR. It serves one core at a time from a word-addressed on-chip RAM and pulses that core's `finishedReadMemoryDataGlobal` or `finishedWriteMemoryDataGlobal`. It sits between the core array and global memory, next to a host preload port used before kernel launch.

---
 rtl/gpu_mem_pkg.sv | 12 +
 rtl/gpu_global_ram.sv | 29 ++
 rtl/global_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_global_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU global-memory path: responder FSM states and the data word width.
package gpu_mem_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } state_e;

endpackage

// File: rtl/gpu_global_ram.sv
// Single-port word-addressed RAM with a registered read port (1-cycle latency), no reset on contents.
module gpu_global_ram
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read-first: a write cycle returns the old word, which no caller depends on.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/global_mem_responder.sv
// Round-robin responder serving one core's global-memory read/write at a time from on-chip RAM,
// with a host preload port that takes priority while idle.
module global_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             readingMemoryDataGlobal,
  input  logic [NUM_CORES-1:0]             writingMemoryDataGlobal,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  coreMar,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  coreMdr,
  output logic [NUM_CORES-1:0]             finishedReadMemoryDataGlobal,
  output logic [NUM_CORES-1:0]             finishedWriteMemoryDataGlobal,
  output logic [DATA_WIDTH-1:0]            globalReadData,
  input  logic                             hostWrite,
  input  logic [ADDR_WIDTH-1:0]            hostAddr,
  input  logic [DATA_WIDTH-1:0]            hostWriteData,
  output logic                             busy
);

  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_write_q, op_write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_CORES-1:0]  req;
  logic [DATA_WIDTH-1:0] mar_arr [NUM_CORES];
  logic [DATA_WIDTH-1:0] mdr_arr [NUM_CORES];
  logic [DATA_WIDTH-1:0] mar_sel;
  logic [PtrW-1:0]       cand, sel_idx;
  logic                  sel_valid, grant_now;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                  unused_mar_hi;

  assign req = readingMemoryDataGlobal | writingMemoryDataGlobal;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      mar_arr[i] = coreMar[i*DATA_WIDTH +: DATA_WIDTH];
      mdr_arr[i] = coreMdr[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First requester scanning upward from rr_ptr_q, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = PtrW'((32'(rr_ptr_q) + i) % NUM_CORES);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign grant_now     = (state_q == StIdle) && !hostWrite && sel_valid;
  assign mar_sel       = mar_arr[sel_idx];
  assign unused_mar_hi = ^mar_sel[DATA_WIDTH-1:ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    grant_q    <= grant_d;
    addr_q     <= addr_d;
    data_q     <= data_d;
    op_write_q <= op_write_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant_now) state_d = StAccess;
      StAccess:  state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_write_d = op_write_q;
    rr_ptr_d   = rr_ptr_q;
    rdata_d    = rdata_q;
    if (grant_now) begin
      grant_d    = sel_idx;
      addr_d     = mar_sel[ADDR_WIDTH-1:0];
      data_d     = mdr_arr[sel_idx];
      op_write_d = writingMemoryDataGlobal[sel_idx];
    end
    if (state_q == StRespond) begin
      rr_ptr_d = PtrW'((32'(grant_q) + 1) % NUM_CORES);
      if (!op_write_q) rdata_d = ram_rdata;
    end
  end

  // RAM port: host preload in Idle, latched transaction in Access; reset blocks any write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = data_q;
    if (!reset) begin
      if (state_q == StIdle && hostWrite) begin
        ram_we    = 1'b1;
        ram_addr  = hostAddr;
        ram_wdata = hostWriteData;
      end else if (state_q == StAccess) begin
        ram_we = op_write_q;
      end
    end
  end

  always_comb begin
    finishedReadMemoryDataGlobal  = '0;
    finishedWriteMemoryDataGlobal = '0;
    globalReadData                = rdata_q;
    busy                          = (state_q != StIdle);
    if (state_q == StRespond) begin
      if (op_write_q) begin
        finishedWriteMemoryDataGlobal[grant_q] = 1'b1;
      end else begin
        finishedReadMemoryDataGlobal[grant_q] = 1'b1;
        globalReadData                        = ram_rdata;
      end
    end
  end

  gpu_global_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_global_mem_responder.sv
// Directed bench for global_mem_responder: vector table of single transactions plus
// contention, fairness, host-priority and reset-in-Access sequences.
module tb_global_mem_responder;

  localparam int NC = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] rd_req, wr_req;
  logic [NC*32-1:0] mar, mdr;
  logic [NC-1:0] fin_r, fin_w;
  logic [31:0]   grd;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_data;
  logic          busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          is_host;
    int          core;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  global_mem_responder #(
    .NUM_CORES (NC),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .readingMemoryDataGlobal      (rd_req),
    .writingMemoryDataGlobal      (wr_req),
    .coreMar                      (mar),
    .coreMdr                      (mdr),
    .finishedReadMemoryDataGlobal (fin_r),
    .finishedWriteMemoryDataGlobal(fin_w),
    .globalReadData               (grd),
    .hostWrite                    (host_we),
    .hostAddr                     (host_addr),
    .hostWriteData                (host_data),
    .busy                         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic host_write(input logic [31:0] addr, input logic [31:0] data, input string name);
    @(posedge clk); #1;
    host_we   = 1'b1;
    host_addr = addr[AW-1:0];
    host_data = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Raise one core's request, measure cycles to its finished pulse, check the pulse and data.
  task automatic do_txn(input int core, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp, input int exp_lat,
                        input bit host, input string name);
    logic [31:0]   prev_rd;
    logic [NC-1:0] onehot;
    int            lat;
    bit            seen;
    @(posedge clk); #1;
    prev_rd = grd;
    onehot  = '0;
    onehot[core] = 1'b1;
    mar[core*32 +: 32] = addr;
    mdr[core*32 +: 32] = data;
    rd_req[core] = rd;
    wr_req[core] = wr;
    if (host) begin
      host_we   = 1'b1;
      host_addr = addr[AW-1:0];
      host_data = exp;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if ((fin_r | fin_w) != '0) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        host_we = 1'b0;
        lat++;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_fin_w"}, 32'(fin_w), wr ? 32'(onehot) : 32'd0);
    check({name, "_fin_r"}, 32'(fin_r), wr ? 32'd0 : 32'(onehot));
    check({name, "_data"}, grd, wr ? prev_rd : exp);
    @(posedge clk); #1;
    rd_req[core] = 1'b0;
    wr_req[core] = 1'b0;
    host_we      = 1'b0;
    @(negedge clk);
    check({name, "_pulse_end"}, 32'(fin_r | fin_w), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          first[NC];
    int          order[$];
    int          cyc;
    logic [NC-1:0] clr;
    logic [NC-1:0] fin_acc;

    reset = 1'b1; rd_req = '0; wr_req = '0; mar = '0; mdr = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_fin_r", 32'(fin_r), 32'd0);
    check("reset_fin_w", 32'(fin_w), 32'd0);
    check("reset_data", grd, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    host_write(32'h5, 32'hDEAD_BEEF, "preload5");

    // Contention: all cores read in the first cycle after reset.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < NC; i++) begin
      mar[i*32 +: 32] = 32'h5;
      first[i] = -1;
    end
    rd_req = '1;
    cyc = 0;
    while (cyc < 16) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (fin_r[i] && first[i] < 0) begin
          first[i] = cyc;
          check($sformatf("contend_data%0d", i), grd, 32'hDEAD_BEEF);
        end
      end
      clr = fin_r;
      @(posedge clk); #1;
      rd_req = rd_req & ~clr;
      cyc++;
    end
    for (int i = 0; i < NC; i++)
      check($sformatf("contend_cycle%0d", i), 32'(first[i]), 32'(2 + 3 * i));
    rd_req = '0;

    // Fairness: pointer is back at 0; core 0 keeps requesting while core 2 waits.
    @(posedge clk); #1;
    rd_req = 4'b0101;
    cyc = 0;
    while (cyc < 20 && order.size() < 3) begin
      @(negedge clk);
      clr = '0;
      for (int i = 0; i < NC; i++)
        if (fin_r[i]) order.push_back(i);
      if (fin_r[2]) clr[2] = 1'b1;
      @(posedge clk); #1;
      rd_req = rd_req & ~clr;
      cyc++;
    end
    rd_req = '0;
    while (order.size() < 3) order.push_back(-1);
    check("fair_first", 32'(order[0]), 32'd0);
    check("fair_second", 32'(order[1]), 32'd2);
    check("fair_third", 32'(order[2]), 32'd0);

    vecs[0] = '{0, 0, 1, 0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, "rd5"};
    vecs[1] = '{0, 1, 0, 1, 32'h0000_0010, 32'h1234_5678, 32'h0,         "wr10"};
    vecs[2] = '{0, 3, 1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, "rd10"};
    vecs[3] = '{0, 2, 1, 0, 32'h0000_1005, 32'h0,         32'hDEAD_BEEF, "alias1005"};
    vecs[4] = '{0, 1, 1, 1, 32'h0000_0030, 32'h0BAD_F00D, 32'h0,         "rdwr30"};
    vecs[5] = '{0, 0, 1, 0, 32'hFFFF_F030, 32'h0,         32'h0BAD_F00D, "aliasF030"};
    vecs[6] = '{1, 0, 0, 0, 32'h0000_0040, 32'h55AA_55AA, 32'h0,         "host40"};
    vecs[7] = '{0, 3, 1, 0, 32'h0000_0040, 32'h0,         32'h55AA_55AA, "rd40"};
    vecs[8] = '{0, 2, 0, 1, 32'h0000_0010, 32'h0F0F_0F0F, 32'h0,         "wr10b"};
    vecs[9] = '{0, 1, 1, 0, 32'h0000_0010, 32'h0,         32'h0F0F_0F0F, "raw10"};

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_host) host_write(vecs[v].addr, vecs[v].data, vecs[v].name);
      else do_txn(vecs[v].core, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data,
                  vecs[v].exp, 2, 1'b0, vecs[v].name);
    end

    // Host write in the same Idle cycle as a core read delays the grant by one cycle.
    do_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_2222, 3, 1'b1, "host_prio");

    // Reset while a write sits in Access.
    @(posedge clk); #1;
    mar[2*32 +: 32] = 32'h40;
    mdr[2*32 +: 32] = 32'hFFFF_FFFF;
    wr_req[2] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    wr_req[2] = 1'b0;
    @(negedge clk);
    check("rst_access_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_after_busy", 32'(busy), 32'd0);
    fin_acc = fin_r | fin_w;
    repeat (3) begin
      @(negedge clk);
      fin_acc = fin_acc | fin_r | fin_w;
    end
    check("rst_no_pulse", 32'(fin_acc), 32'd0);
    do_txn(2, 1'b1, 1'b0, 32'h40, 32'h0, 32'h55AA_55AA, 2, 1'b0, "rst_ram_kept");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
